// File: rtl/dff_enable_pkg.sv
// Shared helpers for the dff_enable storage cell.
// Holds the 2:1 selector used as the hold/load mux in front of each flop.
package dff_enable_pkg;

    // 2:1 selector matching the mux2_1 leaf: sel=0 picks i0, sel=1 picks i1.
    // An unknown select propagates as X wherever i0 and i1 differ.
    function automatic logic mux2(
        input logic sel,
        input logic i0,
        input logic i1
    );
        return sel ? i1 : i0;
    endfunction

endpackage

// File: rtl/dff_enable_bit.sv
// Single-bit storage cell: hold/load mux feeding an async-reset D flip-flop.
// enable=1 loads d on the rising edge, enable=0 recirculates q.
module dff_enable_bit
    import dff_enable_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic d,
    output logic q
);

    logic nextQ;

    // Hold/load selection: i0 is the current state, i1 the new data.
    always_comb begin
        nextQ = mux2(enable, q, d);
    end

    // State flop with asynchronous active-low reset to RESET_VALUE.
    // NOTE: non-blocking assignment so every bit samples nextQ from before the edge.
    // NOTE: reset is in the sensitivity list, so q is forced without a clock and
    //       reset wins over a coincident rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= nextQ;
        end
    end

endmodule

// File: rtl/dff_enable.sv
// Parameterised D register with load enable.
// WIDTH independent dff_enable_bit cells share clk, reset and enable; there is
// no cross-bit logic. Used for pipeline registers, PC and register-file words.
module dff_enable
    import dff_enable_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // One storage cell per bit, each with its own slice of RESET_VALUE.
    for (genvar i = 0; i < WIDTH; i++) begin : gBit
        dff_enable_bit #(
            .RESET_VALUE (RESET_VALUE[i])
        ) bitCell (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .d      (d[i]),
            .q      (q[i])
        );
    end

endmodule

// File: tb/tb_dff_enable.sv
// Self-checking bench for dff_enable.
// Three instances share the stimulus: 8-bit with reset value 8'h00, 8-bit with
// reset value 8'h3C, and the single-bit cell (fed from d[0]). A bench-side
// model of all three pushes expected values when stimulus is driven; they are
// popped and compared #1 after the rising edge that should produce them.
module tb_dff_enable;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       w1;
    } expect_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] d;
    logic [7:0] qA;
    logic [7:0] qB;
    logic       q1;

    expect_t    sb[$];
    expect_t    e;
    logic [7:0] mA;
    logic [7:0] mB;
    logic       m1;
    int         vectors;
    int         misses;

    dff_enable #(.WIDTH(8), .RESET_VALUE(8'h00)) dutA (
        .clk(clk), .reset(reset), .enable(enable), .d(d), .q(qA)
    );

    dff_enable #(.WIDTH(8), .RESET_VALUE(8'h3C)) dutB (
        .clk(clk), .reset(reset), .enable(enable), .d(d), .q(qB)
    );

    dff_enable #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .d(d[0]), .q(q1)
    );

    // 200 ns clock period; rising edges at 100, 300, 500, ...
    initial clk = 1'b0;
    always #100 clk = ~clk;

    // Runaway guard.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Drive one cycle of stimulus at the falling edge and queue what the
    // next rising edge must produce.
    task automatic apply(input logic en, input logic [7:0] dv);
        @(negedge clk);
        enable = en;
        d      = dv;
        if (en) begin
            mA = dv;
            mB = dv;
            m1 = dv[0];
        end
        sb.push_back('{a: mA, b: mB, w1: m1});
    endtask

    // Asynchronous reset forces the reset value between edges, no clock needed.
    task automatic test_reset();
        #50;
        d      = 8'hFF;
        enable = 1'b1;
        reset  = 1'b0;
        mA = 8'h00; mB = 8'h3C; m1 = 1'b0;
        #1;
        vectors++;
        if ({qA, qB, q1} !== {8'h00, 8'h3C, 1'b0}) begin
            misses++;
            $display("FAIL reset_async: q=%h/%h/%b required 00/3c/0", qA, qB, q1);
        end
        #4;
        enable = 1'b0;
        d      = 8'h00;
        #5;
        reset = 1'b1;
        #1;
        vectors++;
        if ({qA, qB, q1} !== {8'h00, 8'h3C, 1'b0}) begin
            misses++;
            $display("FAIL reset_release: q=%h/%h/%b required 00/3c/0", qA, qB, q1);
        end
    endtask

    // After release with enable=0, edges must not disturb the reset value.
    task automatic test_hold_after_release();
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 8'h00);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
                misses++;
                $display("FAIL hold_after_release: q=%h/%h/%b required %h/%h/%b",
                         qA, qB, q1, e.a, e.b, e.w1);
            end
        end
    endtask

    // Load all ones: q must change at the edge and not before it.
    task automatic test_load();
        apply(1'b1, 8'hFF);
        #50;
        vectors++;
        if ({qA, qB, q1} !== {8'h00, 8'h3C, 1'b0}) begin
            misses++;
            $display("FAIL load_early: q=%h/%h/%b required 00/3c/0", qA, qB, q1);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
            misses++;
            $display("FAIL load: q=%h/%h/%b required %h/%h/%b", qA, qB, q1, e.a, e.b, e.w1);
        end
    endtask

    // enable=0 with d changed: q holds across several edges.
    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, (i == 1) ? 8'h5A : 8'h00);
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
                misses++;
                $display("FAIL hold: q=%h/%h/%b required %h/%h/%b", qA, qB, q1, e.a, e.b, e.w1);
            end
        end
    endtask

    // Mid-cycle reset pulse, then a load of 8'hA5 on the next edge.
    task automatic test_reset_midcycle();
        @(negedge clk);
        #40;
        reset = 1'b0;
        mA = 8'h00; mB = 8'h3C; m1 = 1'b0;
        #1;
        vectors++;
        if ({qA, qB, q1} !== {8'h00, 8'h3C, 1'b0}) begin
            misses++;
            $display("FAIL reset_midcycle: q=%h/%h/%b required 00/3c/0", qA, qB, q1);
        end
        #9;
        reset = 1'b1;
        apply(1'b1, 8'hA5);
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
            misses++;
            $display("FAIL load_after_reset: q=%h/%h/%b required %h/%h/%b",
                     qA, qB, q1, e.a, e.b, e.w1);
        end
    endtask

    // d and enable glitch between edges; only the value present at the edge counts.
    task automatic test_toggle();
        logic [7:0] vals [6] = '{8'h01, 8'hFE, 8'h33, 8'hC4, 8'h00, 8'h80};
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, vals[i]);
            #30;
            d      = ~vals[i];
            enable = 1'b0;
            #30;
            d      = vals[i];
            enable = 1'b1;
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
                misses++;
                $display("FAIL toggle[%0d]: q=%h/%h/%b required %h/%h/%b",
                         i, qA, qB, q1, e.a, e.b, e.w1);
            end
            // Changing d after the edge must not leak through to q.
            d = ~vals[i];
            #20;
            vectors++;
            if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
                misses++;
                $display("FAIL no_passthru[%0d]: q=%h/%h/%b required %h/%h/%b",
                         i, qA, qB, q1, e.a, e.b, e.w1);
            end
        end
    endtask

    // Non-zero reset value: q held at 8'h3C for the whole time reset is low,
    // even with enable=1 and clock edges arriving.
    task automatic test_reset_value();
        @(negedge clk);
        enable = 1'b1;
        d      = 8'hFF;
        reset  = 1'b0;
        mA = 8'h00; mB = 8'h3C; m1 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({qA, qB, q1} !== {8'h00, 8'h3C, 1'b0}) begin
            misses++;
            $display("FAIL reset_value_held: q=%h/%h/%b required 00/3c/0", qA, qB, q1);
        end
        @(negedge clk);
        #10;
        reset  = 1'b1;
        enable = 1'b0;
        apply(1'b0, 8'h77);
        @(posedge clk); #1;
        e = sb.pop_front();
        vectors++;
        if ({qA, qB, q1} !== {e.a, e.b, e.w1}) begin
            misses++;
            $display("FAIL reset_value_release: q=%h/%h/%b required %h/%h/%b",
                     qA, qB, q1, e.a, e.b, e.w1);
        end
    endtask

    initial begin
        vectors = 0;
        misses  = 0;
        reset   = 1'b1;
        enable  = 1'b0;
        d       = 8'h00;
        mA = 8'h00; mB = 8'h3C; m1 = 1'b0;

        test_reset();
        test_hold_after_release();
        test_load();
        test_hold();
        test_reset_midcycle();
        test_toggle();
        test_reset_value();

        if (sb.size() != 0) begin
            misses++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
